arb_rr4_ctrl: RTL
=================

ARB_RR4_CTRL -- requirements
Module: arb_rr4_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, 15, maximum cycles a grant may be held when ARB_RR4_TIMEOUT_EN is defined (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request, bit i = requester i.
REQ-005 done  input  1  release strobe from the current owner, sampled only in BUSY.
REQ-006 gnt  output  4  one-hot grant, registered.
REQ-007 gnt_id  output  2  binary index of the granted requester, registered.
REQ-008 gnt_v  output  1  grant valid, high exactly when gnt is non-zero.
REQ-009 tmo  output  1  one-cycle pulse on a forced release; absent (tied 0) when the timeout is not compiled in.

Function
REQ-010 Two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-011 gnt SHALL be zero or one-hot; {gnt_v, gnt_id} SHALL always equal the 4-to-2 encoding of gnt: 0001->100, 0010->101, 0100->110, 1000->111, 0000->000.
REQ-012 Priority pointer ptr[1:0]: the search starts at index ptr and proceeds ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-013 IDLE with req != 0: the first set bit in search order is granted; state goes to BUSY; gnt/gnt_id/gnt_v are valid on the next edge (grant latency 1 cycle).
REQ-014 IDLE with req == 0: state, ptr and outputs are unchanged.
REQ-015 BUSY: the grant is held while req[gnt_id]=1 and done=0, regardless of other requests.
REQ-016 BUSY with done=1, or with req[gnt_id]=0: on the next edge gnt clears to 0, state goes to IDLE, and ptr becomes gnt_id+1 (mod 4, so 3 wraps to 0).
REQ-017 After a release, the earliest new grant is valid two edges after the release cycle (one mandatory IDLE cycle with gnt=0).
REQ-018 done asserted in IDLE is ignored.
REQ-019 Requests that change while in IDLE are re-evaluated every cycle; there is no request latching.
REQ-020 Fairness: any requester that holds req high is granted within 3 intervening grants.

Reset
REQ-021 While rst_n=0, asynchronously: state=IDLE, ptr=0, gnt=0000, gnt_id=00, gnt_v=0, tmo=0, hold counter=0.
REQ-022 Reset asserted in BUSY drops the grant immediately, without waiting for a clock edge; after deassertion the first grant follows REQ-013 with ptr=0.

Configuration
REQ-023 Macro ARB_RR4_TIMEOUT_EN defined: a 4-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
REQ-024 With ARB_RR4_TIMEOUT_EN, when the counter equals MAX_HOLD in BUSY, release is forced per REQ-016 and tmo pulses for 1 cycle, coincident with gnt clearing.
REQ-025 With ARB_RR4_TIMEOUT_EN, done or a dropped request on the same cycle as the timeout is a normal release with tmo=0.
REQ-026 Without ARB_RR4_TIMEOUT_EN: no counter is instantiated, tmo is constant 0, and a grant is held indefinitely.

Verification
REQ-027 Reset, then req=0101 held -> gnt=0001, id=00 one cycle later; done pulse -> gnt=0000 for 1 cycle, then gnt=0100, id=10.
REQ-028 req=1111 held, done every 3rd cycle -> grant order 0,1,2,3,0; gnt_v is never high with gnt=0000.
REQ-029 Owner 3 releases (ptr wraps to 0) with req=1001 -> next grant is 0001.
REQ-030 Owner drops req without done -> release on the next edge, identical to done=1.
REQ-031 Timeout enabled, MAX_HOLD=4, req=0010 held, done=0 -> tmo pulse with gnt clearing after 5 BUSY cycles; regrant of 0010 two cycles later. Timeout disabled -> grant persists for 100+ cycles.
REQ-032 rst_n pulled low mid-BUSY between clock edges -> gnt=0000 and gnt_v=0 immediately; after release with req=1000 -> gnt=1000, id=11.

Source files
------------

// File: rtl/arb_rr4_ctrl.sv
// arb_rr4_ctrl: 4-way round-robin arbiter; an owner holds its grant until it
// signals done or drops its request. Define ARB_RR4_TIMEOUT_EN to add a
// hold counter that forces release after MAX_HOLD+1 busy cycles and pulses tmo.
module arb_rr4_ctrl #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_v,
    output logic       tmo
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] rot;
    logic [1:0] win;
    logic       rel;
    logic       stop;
`ifdef ARB_RR4_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    logic       hit;
`endif
    // State register, pointer, grant and optional hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'd0;
`ifdef ARB_RR4_TIMEOUT_EN
            cnt_q   <= 4'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
`ifdef ARB_RR4_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end
    // Next state: rotate requests so index ptr lands at bit 0, pick lowest set bit
    always_comb begin
        rot     = 4'({req, req} >> ptr_q);
        win     = ptr_q + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
        rel     = done | ~req[gnt_id];
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
`ifdef ARB_RR4_TIMEOUT_EN
        hit     = cnt_q == 4'(MAX_HOLD);
        stop    = rel | hit;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`else
        stop    = rel;
`endif
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = BUSY;
                gnt_d   = 4'b0001 << win;
`ifdef ARB_RR4_TIMEOUT_EN
                cnt_d   = 4'd0;
`endif
            end
        end else if (stop) begin
            state_d = IDLE;
            gnt_d   = 4'd0;
            ptr_d   = gnt_id + 2'd1;
`ifdef ARB_RR4_TIMEOUT_EN
            tmo_d   = ~rel;
`endif
        end else begin
`ifdef ARB_RR4_TIMEOUT_EN
            cnt_d   = cnt_q + 4'd1;
`endif
        end
    end
    // Outputs: id and valid are pure encodings of the registered grant
    always_comb begin
        gnt    = gnt_q;
        gnt_id = gnt_q[1] ? 2'd1 : gnt_q[2] ? 2'd2 : gnt_q[3] ? 2'd3 : 2'd0;
        gnt_v  = |gnt_q;
`ifdef ARB_RR4_TIMEOUT_EN
        tmo    = tmo_q;
`else
        tmo    = 1'b0 && MAX_HOLD > 0;
`endif
    end
endmodule
